ahb_slave_mem: RTL and testbench

AHB 2.0 memory-backed responder (slave) on the same bus as the team's AHB master.
- Serves single and burst reads and writes from an internal byte-enabled RAM.
- Wait states are programmable. ERROR and RETRY use the two-cycle response.
- Acts as the reference target for master bring-up, including the split/retry pipeline-rollback path.

---
 rtl/ahb_pkg.sv | 53 +++++
 rtl/ahb_slave_mem_if.sv | 27 ++
 rtl/ahb_slave_ram.sv | 24 ++
 rtl/ahb_slave_mem.sv | 145 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB 2.0 encodings and address helpers used by both the master and the memory slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;
  localparam logic [1:0] HRESP_SPLIT = 2'd2;
  localparam logic [1:0] HRESP_RETRY = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP1, S_RESP2} slave_state_e;

  // Little-endian lane mask; bits above data_wdt/8 are always zero.
  function automatic logic [7:0] byte_en(input logic [2:0] addr_lsb, input logic [2:0] size,
                                         input int data_wdt);
    int lanes;
    int nb;
    int off;
    logic [7:0] m;
    lanes = data_wdt / 8;
    nb    = (size > 3'd3) ? 8 : (1 << size);
    off   = int'(addr_lsb) % lanes;
    m     = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + nb && i < lanes) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic is_aligned(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] mask;
    mask = (32'd1 << size) - 32'd1;
    return (addr & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB slave-side bus bundle: address/control, write data, and the slave's response signals.
interface ahb_slave_mem_if #(parameter int DATA_WDT = 32);
  logic                i_hsel;
  logic [31:0]         i_haddr;
  logic [1:0]          i_htrans;
  logic                i_hwrite;
  logic [2:0]          i_hsize;
  logic [2:0]          i_hburst;
  logic [DATA_WDT-1:0] i_hwdata;
  logic                i_hready;
  logic                i_retry;
  logic                o_hready;
  logic [1:0]          o_hresp;
  logic [DATA_WDT-1:0] o_hrdata;

  // An address phase is taken when i_hsel, i_hready and i_htrans[1] are all high on a
  // clock edge; its data phase ends on the first later edge where o_hready is high.
  modport slave (
    input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready, i_retry,
    output o_hready, o_hresp, o_hrdata
  );

  modport master (
    output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready, i_retry,
    input  o_hready, o_hresp, o_hrdata
  );
endinterface

// File: rtl/ahb_slave_ram.sv
// Word-organised RAM with per-byte write enables, clocked write and combinational read.
module ahb_slave_ram #(
  parameter int DATA_WDT  = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [DATA_WDT/8-1:0]        be,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [DATA_WDT-1:0]          wdata,
  output logic [DATA_WDT-1:0]          rdata
);
  logic [DATA_WDT-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WDT / 8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_slave_mem.sv
// AHB 2.0 memory slave: programmable wait states, two-cycle ERROR/RETRY, byte-enabled RAM.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DATA_WDT    = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 i_hclk,
  input  logic                 i_hreset_n,
  ahb_slave_mem_if.slave       bus,
  output slave_state_e         o_state
);
  localparam int          NB         = DATA_WDT / 8;
  localparam int          LSB        = $clog2(NB);
  localparam int          AW         = $clog2(MEM_DEPTH);
  localparam logic [31:0] BYTE_RANGE = 32'(MEM_DEPTH * NB);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_e        state, state_d;
  logic [3:0]          wait_cnt, wait_cnt_d;
  logic                pend, pend_d;
  logic [31:0]         addr_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic [1:0]          resp_q;
  logic [1:0]          cls;
  logic                accept;
  logic                hready;
  logic [1:0]          hresp;
  logic                data_done;
  logic                rd_phase;
  logic [7:0]          be_full;
  logic [DATA_WDT-1:0] ram_rdata;
  logic [DATA_WDT-1:0] hrdata_q;
  logic [DATA_WDT-1:0] rdata_mux;
  logic                unused_ok;

  // RESP1/RESP2 and WAIT never take a new address phase.
  assign accept = bus.i_hsel && bus.i_hready && bus.i_htrans[1] && (state == S_IDLE);

  always_comb begin
    cls = HRESP_OKAY;
    if (bus.i_retry)                                      cls = HRESP_RETRY;
    else if (bus.i_haddr >= BYTE_RANGE)                   cls = HRESP_ERROR;
    else if (!is_aligned(bus.i_haddr, bus.i_hsize))       cls = HRESP_ERROR;
    else if ((32'd8 << bus.i_hsize) > 32'(DATA_WDT))      cls = HRESP_ERROR;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      pend     <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      pend     <= pend_d;
    end
  end

  // pend marks the single o_hready=1 cycle that ends an OKAY data phase.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    pend_d     = 1'b0;
    hready     = 1'b1;
    hresp      = HRESP_OKAY;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cls != HRESP_OKAY) begin
            state_d = S_RESP1;
          end else if (WAIT_STATES > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        hready = 1'b0;
        if (wait_cnt == 4'd0) begin
          state_d = S_IDLE;
          pend_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt - 4'd1;
        end
      end
      S_RESP1: begin
        hready  = 1'b0;
        hresp   = resp_q;
        state_d = S_RESP2;
      end
      S_RESP2: begin
        hresp   = resp_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      addr_q  <= 32'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      resp_q  <= HRESP_OKAY;
    end else if (accept) begin
      addr_q  <= bus.i_haddr;
      write_q <= bus.i_hwrite;
      size_q  <= bus.i_hsize;
      resp_q  <= cls;
    end
  end

  assign data_done = (state == S_IDLE) && pend;
  assign rd_phase  = data_done && !write_q;
  assign be_full   = byte_en(addr_q[2:0], size_q, DATA_WDT);

  ahb_slave_ram #(.DATA_WDT(DATA_WDT), .MEM_DEPTH(MEM_DEPTH)) u_ram (
    .clk   (i_hclk),
    .we    (data_done && write_q),
    .be    (be_full[NB-1:0]),
    .addr  (addr_q[LSB +: AW]),
    .wdata (bus.i_hwdata),
    .rdata (ram_rdata)
  );

  // Read data is live only in the completing read cycle; otherwise the last value is held.
  assign rdata_mux = rd_phase ? ram_rdata : hrdata_q;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) hrdata_q <= '0;
    else             hrdata_q <= rdata_mux;
  end

  assign bus.o_hready = hready;
  assign bus.o_hresp  = hresp;
  assign bus.o_hrdata = rdata_mux;
  assign o_state      = state;

  assign unused_ok = ^{bus.i_hburst, bus.i_htrans[0], addr_q[31:LSB+AW]};
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a two-wait instance against a byte-level memory model.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  localparam int MAX_BEATS = 64;
  localparam int MAX_CYC   = 4000;
  localparam int RANGE     = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        dsel, hsel, hwrite, retry;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;

  ahb_slave_mem_if #(.DATA_WDT(32)) bus0();
  ahb_slave_mem_if #(.DATA_WDT(32)) bus1();

  assign bus0.i_hsel   = hsel && !dsel;
  assign bus1.i_hsel   = hsel && dsel;
  assign bus0.i_haddr  = haddr;
  assign bus1.i_haddr  = haddr;
  assign bus0.i_htrans = htrans;
  assign bus1.i_htrans = htrans;
  assign bus0.i_hwrite = hwrite;
  assign bus1.i_hwrite = hwrite;
  assign bus0.i_hsize  = hsize;
  assign bus1.i_hsize  = hsize;
  assign bus0.i_hburst = hburst;
  assign bus1.i_hburst = hburst;
  assign bus0.i_hwdata = hwdata;
  assign bus1.i_hwdata = hwdata;
  assign bus0.i_retry  = retry;
  assign bus1.i_retry  = retry;
  assign bus0.i_hready = bus0.o_hready;
  assign bus1.i_hready = bus1.o_hready;

  slave_state_e st0, st1;

  ahb_slave_mem #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .bus(bus0.slave), .o_state(st0));
  ahb_slave_mem #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut1 (
    .i_hclk(clk), .i_hreset_n(rst_n), .bus(bus1.slave), .o_state(st1));

  logic         hready_o;
  logic [1:0]   hresp_o;
  logic [31:0]  hrdata_o;
  slave_state_e st_o;
  assign hready_o = dsel ? bus1.o_hready : bus0.o_hready;
  assign hresp_o  = dsel ? bus1.o_hresp  : bus0.o_hresp;
  assign hrdata_o = dsel ? bus1.o_hrdata : bus0.o_hrdata;
  assign st_o     = dsel ? st1 : st0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] b_addr  [MAX_BEATS];
  logic        b_write [MAX_BEATS];
  logic [2:0]  b_size  [MAX_BEATS];
  logic [31:0] b_wdata [MAX_BEATS];
  logic        b_retry [MAX_BEATS];
  logic [1:0]  r_resp    [MAX_BEATS];
  logic [1:0]  r_resp_lo [MAX_BEATS];
  logic [31:0] r_rdata   [MAX_BEATS];
  int          r_waits   [MAX_BEATS];
  int          total_cyc;

  logic [7:0] ref_mem [2][RANGE];

  function automatic void set_beat(input int i, input logic [31:0] a, input logic w,
                                   input logic [2:0] s, input logic [31:0] d, input logic r);
    b_addr[i] = a; b_write[i] = w; b_size[i] = s; b_wdata[i] = d; b_retry[i] = r;
  endfunction

  // Reference: classify the beat from the address rules, then apply it to the byte model.
  function automatic void model_beat(input int i, output logic [1:0] er, output logic [31:0] ed);
    int nbytes;
    logic [31:0] a;
    a      = b_addr[i];
    nbytes = 1 << b_size[i];
    ed     = '0;
    if (b_retry[i])                     er = HRESP_RETRY;
    else if (a >= 32'(RANGE))           er = HRESP_ERROR;
    else if (a % 32'(nbytes) != 32'd0)  er = HRESP_ERROR;
    else if (nbytes > 4)                er = HRESP_ERROR;
    else begin
      er = HRESP_OKAY;
      if (b_write[i]) begin
        for (int k = 0; k < nbytes; k++)
          ref_mem[dsel][a + 32'(k)] = b_wdata[i][8*((int'(a) + k) % 4) +: 8];
      end else begin
        for (int k = 0; k < 4; k++)
          ed[8*k +: 8] = ref_mem[dsel][(a & ~32'd3) + 32'(k)];
      end
    end
  endfunction

  // Pipelined master: drives beats 0..n-1, honours wait states and the two-cycle response.
  task automatic run_beats(input int n);
    int ai, di, pa, cyc;
    logic idle_next, brk, hr;
    logic [1:0] rs;
    logic [31:0] rd;
    ai = 0; di = -1; cyc = 0; idle_next = 1'b0; brk = 1'b1; total_cyc = 0;
    for (int k = 0; k < n; k++) begin r_waits[k] = 0; r_resp_lo[k] = HRESP_OKAY; end
    while ((ai < n || di >= 0) && cyc < MAX_CYC) begin
      if (ai < n && !idle_next) begin
        pa = ai; hsel = 1'b1; haddr = b_addr[ai]; hwrite = b_write[ai]; hsize = b_size[ai];
        htrans = brk ? HTRANS_NONSEQ : HTRANS_SEQ; retry = b_retry[ai];
      end else begin
        pa = -1; htrans = HTRANS_IDLE; retry = 1'b0;
      end
      hwdata = (di >= 0) ? b_wdata[di] : 32'd0;
      @(negedge clk);
      hr = hready_o; rs = hresp_o; rd = hrdata_o; cyc++;
      idle_next = 1'b0;
      if (di >= 0) begin
        total_cyc++;
        if (!hr) begin
          r_waits[di]++; r_resp_lo[di] = rs;
          if (rs != HRESP_OKAY) idle_next = 1'b1;
        end else begin
          r_resp[di] = rs; r_rdata[di] = rd;
        end
      end
      @(posedge clk); #1;
      if (hr) begin
        if (pa >= 0) begin ai++; brk = 1'b0; end
        if (di >= 0 && rs != HRESP_OKAY) brk = 1'b1;
        di = pa;
      end
    end
    hsel = 1'b0; htrans = HTRANS_IDLE; retry = 1'b0;
    if (cyc >= MAX_CYC) begin
      n_checks++; n_errors++;
      $display("FAIL run_timeout: got %0d cycles, required completion within %0d", cyc, MAX_CYC);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      dsel = d[0]; #1;
      n_checks++; if (hready_o !== 1'b1) begin n_errors++; $display("FAIL reset_hready dut%0d: got %b required 1", d, hready_o); end
      n_checks++; if (hresp_o !== HRESP_OKAY) begin n_errors++; $display("FAIL reset_hresp dut%0d: got %0d required 0", d, hresp_o); end
      n_checks++; if (hrdata_o !== 32'd0) begin n_errors++; $display("FAIL reset_hrdata dut%0d: got %h required 0", d, hrdata_o); end
      n_checks++; if (st_o !== S_IDLE) begin n_errors++; $display("FAIL reset_state dut%0d: got %0d required %0d", d, st_o, S_IDLE); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] er; logic [31:0] ed;
    dsel = 1'b0;
    set_beat(0, 32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 1'b0);
    set_beat(1, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
    run_beats(2);
    for (int i = 0; i < 2; i++) begin
      model_beat(i, er, ed);
      n_checks++; if (r_resp[i] !== er) begin n_errors++; $display("FAIL b2b_resp beat %0d: got %0d required %0d", i, r_resp[i], er); end
      n_checks++; if (r_waits[i] !== 0) begin n_errors++; $display("FAIL b2b_waits beat %0d: got %0d required 0", i, r_waits[i]); end
    end
    n_checks++; if (r_rdata[1] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL b2b_rdata: got %h required deadbeef", r_rdata[1]); end
  endtask

  task automatic test_wait_burst();
    logic [1:0] er; logic [31:0] ed;
    dsel = 1'b1; hburst = HBURST_INCR4;
    for (int i = 0; i < 4; i++) set_beat(i, 32'h20 + 32'(4*i), 1'b1, HSIZE_WORD, $urandom, 1'b0);
    for (int i = 4; i < 8; i++) set_beat(i, 32'h20 + 32'(4*(i-4)), 1'b0, HSIZE_WORD, 32'h0, 1'b0);
    run_beats(4);
    for (int i = 0; i < 4; i++) begin
      model_beat(i, er, ed);
      n_checks++; if (r_resp[i] !== er) begin n_errors++; $display("FAIL wburst_wr_resp beat %0d: got %0d required %0d", i, r_resp[i], er); end
    end
    for (int i = 0; i < 4; i++) set_beat(i, b_addr[i+4], 1'b0, HSIZE_WORD, 32'h0, 1'b0);
    run_beats(4);
    n_checks++; if (total_cyc !== 12) begin n_errors++; $display("FAIL wburst_cycles: got %0d required 12", total_cyc); end
    for (int i = 0; i < 4; i++) begin
      model_beat(i, er, ed);
      n_checks++; if (r_waits[i] !== 2) begin n_errors++; $display("FAIL wburst_waits beat %0d: got %0d required 2", i, r_waits[i]); end
      n_checks++; if (r_resp[i] !== er) begin n_errors++; $display("FAIL wburst_resp beat %0d: got %0d required %0d", i, r_resp[i], er); end
      n_checks++; if (r_rdata[i] !== ed) begin n_errors++; $display("FAIL wburst_rdata beat %0d: got %h required %h", i, r_rdata[i], ed); end
    end
    hburst = HBURST_SINGLE;
  endtask

  task automatic test_byte_write();
    logic [1:0] er; logic [31:0] ed;
    dsel = 1'b0;
    set_beat(0, 32'h10, 1'b1, HSIZE_WORD, 32'h11223344, 1'b0);
    set_beat(1, 32'h13, 1'b1, HSIZE_BYTE, {8'hAA, 24'($urandom)}, 1'b0);
    set_beat(2, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
    run_beats(3);
    for (int i = 0; i < 3; i++) begin
      model_beat(i, er, ed);
      n_checks++; if (r_resp[i] !== er) begin n_errors++; $display("FAIL bytewr_resp beat %0d: got %0d required %0d", i, r_resp[i], er); end
    end
    n_checks++; if (r_rdata[2] !== 32'hAA223344) begin n_errors++; $display("FAIL bytewr_rdata: got %h required aa223344", r_rdata[2]); end
  endtask

  task automatic test_errors();
    logic [1:0] er; logic [31:0] ed;
    int ws;
    for (int d = 0; d < 2; d++) begin
      dsel = d[0]; ws = d * 2;
      set_beat(0, 32'h00, 1'b1, HSIZE_WORD, $urandom, 1'b0);
      set_beat(1, 32'h400, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      set_beat(2, 32'h02, 1'b1, HSIZE_WORD, $urandom, 1'b0);
      set_beat(3, 32'h01, 1'b1, HSIZE_HALF, $urandom, 1'b0);
      set_beat(4, 32'h08, 1'b0, HSIZE_DWORD, 32'h0, 1'b0);
      set_beat(5, 32'h00, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
      run_beats(6);
      for (int i = 0; i < 6; i++) begin
        model_beat(i, er, ed);
        n_checks++; if (r_resp[i] !== er) begin n_errors++; $display("FAIL err_resp dut%0d beat %0d: got %0d required %0d", d, i, r_resp[i], er); end
        if (er != HRESP_OKAY) begin
          n_checks++; if (r_waits[i] !== 1) begin n_errors++; $display("FAIL err_waits dut%0d beat %0d: got %0d required 1", d, i, r_waits[i]); end
          n_checks++; if (r_resp_lo[i] !== er) begin n_errors++; $display("FAIL err_first dut%0d beat %0d: got %0d required %0d", d, i, r_resp_lo[i], er); end
        end else begin
          n_checks++; if (r_waits[i] !== ws) begin n_errors++; $display("FAIL err_okwaits dut%0d beat %0d: got %0d required %0d", d, i, r_waits[i], ws); end
          if (!b_write[i]) begin
            n_checks++; if (r_rdata[i] !== ed) begin n_errors++; $display("FAIL err_rdata dut%0d beat %0d: got %h required %h", d, i, r_rdata[i], ed); end
          end
        end
      end
    end
  endtask

  task automatic test_retry();
    logic [1:0] er; logic [31:0] ed;
    dsel = 1'b0; hburst = HBURST_INCR4;
    set_beat(0, 32'h48, 1'b1, HSIZE_WORD, $urandom, 1'b0);
    for (int i = 1; i < 5; i++) set_beat(i, 32'h40 + 32'(4*(i-1)), 1'b1, HSIZE_WORD, $urandom, i == 3);
    set_beat(5, 32'h48, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
    set_beat(6, 32'h48, 1'b1, HSIZE_WORD, b_wdata[3], 1'b0);
    set_beat(7, 32'h48, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
    run_beats(8);
    for (int i = 0; i < 8; i++) begin
      model_beat(i, er, ed);
      n_checks++; if (r_resp[i] !== er) begin n_errors++; $display("FAIL retry_resp beat %0d: got %0d required %0d", i, r_resp[i], er); end
      if (!b_write[i]) begin
        n_checks++; if (r_rdata[i] !== ed) begin n_errors++; $display("FAIL retry_rdata beat %0d: got %h required %h", i, r_rdata[i], ed); end
      end
    end
    n_checks++; if (r_resp_lo[3] !== HRESP_RETRY || r_waits[3] !== 1) begin
      n_errors++; $display("FAIL retry_two_cycle: got first %0d waits %0d required 3 and 1", r_resp_lo[3], r_waits[3]);
    end
    hburst = HBURST_SINGLE;
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0] er; logic [31:0] ed;
    dsel = 1'b1;
    set_beat(0, 32'h30, 1'b1, HSIZE_WORD, $urandom, 1'b0);
    run_beats(1);
    model_beat(0, er, ed);
    hsel = 1'b1; haddr = 32'h30; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    htrans = HTRANS_IDLE; hsel = 1'b0; hwdata = ~b_wdata[0];
    @(negedge clk);
    n_checks++; if (hready_o !== 1'b0) begin n_errors++; $display("FAIL rstwait_in_wait: got hready %b required 0", hready_o); end
    rst_n = 1'b0; #1;
    n_checks++; if (hready_o !== 1'b1) begin n_errors++; $display("FAIL rstwait_hready: got %b required 1", hready_o); end
    n_checks++; if (hresp_o !== HRESP_OKAY) begin n_errors++; $display("FAIL rstwait_hresp: got %0d required 0", hresp_o); end
    n_checks++; if (st_o !== S_IDLE) begin n_errors++; $display("FAIL rstwait_state: got %0d required %0d", st_o, S_IDLE); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_beat(0, 32'h30, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
    set_beat(1, 32'h30, 1'b1, HSIZE_WORD, $urandom, 1'b0);
    set_beat(2, 32'h30, 1'b0, HSIZE_WORD, 32'h0, 1'b0);
    run_beats(3);
    for (int i = 0; i < 3; i++) begin
      model_beat(i, er, ed);
      n_checks++; if (r_resp[i] !== er || r_waits[i] !== 2) begin n_errors++; $display("FAIL rstwait_resp beat %0d: got %0d/%0d required %0d/2", i, r_resp[i], r_waits[i], er); end
      if (!b_write[i]) begin
        n_checks++; if (r_rdata[i] !== ed) begin n_errors++; $display("FAIL rstwait_rdata beat %0d: got %h required %h", i, r_rdata[i], ed); end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] er; logic [31:0] ed;
    logic [31:0] a; logic [2:0] s;
    int ws;
    for (int d = 0; d < 2; d++) begin
      dsel = d[0]; ws = d * 2;
      for (int i = 0; i < 32; i++) set_beat(i, 32'(4*i), 1'b1, HSIZE_WORD, $urandom, 1'b0);
      run_beats(32);
      for (int i = 0; i < 32; i++) model_beat(i, er, ed);
      for (int i = 0; i < 40; i++) begin
        a = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
        s = ($urandom_range(0, 9) == 0) ? HSIZE_DWORD : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
        set_beat(i, a, 1'($urandom_range(0, 1)), s, $urandom, $urandom_range(0, 9) == 0);
      end
      run_beats(40);
      for (int i = 0; i < 40; i++) begin
        model_beat(i, er, ed);
        n_checks++; if (r_resp[i] !== er) begin n_errors++; $display("FAIL rand_resp dut%0d beat %0d addr %h: got %0d required %0d", d, i, b_addr[i], r_resp[i], er); end
        n_checks++; if (r_waits[i] !== ((er == HRESP_OKAY) ? ws : 1)) begin n_errors++; $display("FAIL rand_waits dut%0d beat %0d: got %0d", d, i, r_waits[i]); end
        if (er == HRESP_OKAY && !b_write[i]) begin
          n_checks++; if (r_rdata[i] !== ed) begin n_errors++; $display("FAIL rand_rdata dut%0d beat %0d addr %h: got %h required %h", d, i, b_addr[i], r_rdata[i], ed); end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; dsel = 1'b0; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = HBURST_SINGLE; hwdata = '0; retry = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    @(posedge clk); #1;
    test_back_to_back();
    test_wait_burst();
    test_byte_write();
    test_errors();
    test_retry();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
